// File: rtl/yuv_lane_select_if.sv
// Pixel-path bundle between the frame-buffer reader and yuv_lane_select.
// Mode count follows YUV_LANE_SELECT_PATTERN_EN the same way the core does.
interface yuv_lane_select_if #(
  parameter int DATA_WD = 16
);
  localparam int LANES  = DATA_WD / 8;
`ifdef YUV_LANE_SELECT_PATTERN_EN
  localparam int NMODES = LANES + 2;
`else
  localparam int NMODES = LANES + 1;
`endif
  localparam int MODE_W = (NMODES > 2) ? $clog2(NMODES) : 1;

  logic               mode_step;
  logic               vs;
  logic               in_valid;
  logic [DATA_WD-1:0] in_data;
  logic [23:0]        yuv_data;
  logic               yuv_valid;
  logic [MODE_W-1:0]  active_mode;
  logic [NMODES-1:0]  mode_led_n;

  modport master (
    output mode_step, vs, in_valid, in_data,
    input  yuv_data, yuv_valid, active_mode, mode_led_n
  );

  modport slave (
    input  mode_step, vs, in_valid, in_data,
    output yuv_data, yuv_valid, active_mode, mode_led_n
  );
endinterface

// File: rtl/yuv_lane_select.sv
// Picks one byte lane of the frame-buffer word (or a constant) as Y for the UVC core.
// Define YUV_LANE_SELECT_PATTERN_EN to add the counting test-pattern mode.
module yuv_lane_select #(
  parameter int         DATA_WD = 16,
  parameter logic [7:0] U_CONST = 8'h80,
  parameter logic [7:0] V_CONST = 8'h80
) (
  input  logic              clk,
  input  logic              rst,
  yuv_lane_select_if.slave  bus
);
  localparam int LANES = DATA_WD / 8;
`ifdef YUV_LANE_SELECT_PATTERN_EN
  localparam int NMODES  = LANES + 2;
  localparam int PATTERN = LANES;
`else
  localparam int NMODES  = LANES + 1;
`endif
  localparam int MODE_W = (NMODES > 2) ? $clog2(NMODES) : 1;
  localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(NMODES - 1);

  logic [MODE_W-1:0] pending_mode_q, pending_mode_d;
  logic [MODE_W-1:0] active_mode_q,  active_mode_d;
  logic              vs_q,           vs_d;
  logic              armed_q,        armed_d;
  logic [23:0]       yuv_data_q,     yuv_data_d;
  logic              yuv_valid_q,    yuv_valid_d;
  logic              frame_start_s;
  logic [7:0]        y_s;
  logic [NMODES-1:0] mode_led_n_s;
`ifdef YUV_LANE_SELECT_PATTERN_EN
  logic [15:0]       pix_cnt_q,      pix_cnt_d;
  logic              parity_q,       parity_d;
`endif

  // Frame boundary detect; armed_q stays low until vs is seen low after reset,
  // so a vs already high at release is not taken as an edge.
  always_comb begin
    vs_d          = bus.vs;
    armed_d       = armed_q | ~bus.vs;
    frame_start_s = bus.vs & ~vs_q & armed_q;
  end

  // Mode stepping is immediate, application waits for the frame boundary
  always_comb begin
    pending_mode_d = pending_mode_q;
    active_mode_d  = active_mode_q;
    if (bus.mode_step) begin
      if (pending_mode_q == LAST_MODE) begin
        pending_mode_d = {MODE_W{1'b0}};
      end else begin
        pending_mode_d = pending_mode_q + MODE_W'(1);
      end
    end else begin
      pending_mode_d = pending_mode_q;
    end
    if (frame_start_s) begin
      active_mode_d = pending_mode_q;
    end else begin
      active_mode_d = active_mode_q;
    end
  end

`ifdef YUV_LANE_SELECT_PATTERN_EN
  // Pattern counter and frame parity; a frame start clears the count even on a valid beat
  always_comb begin
    pix_cnt_d = pix_cnt_q;
    parity_d  = parity_q;
    if (frame_start_s) begin
      pix_cnt_d = 16'h0000;
      parity_d  = ~parity_q;
    end else if (bus.in_valid) begin
      pix_cnt_d = pix_cnt_q + 16'h0001;
      parity_d  = parity_q;
    end else begin
      pix_cnt_d = pix_cnt_q;
      parity_d  = parity_q;
    end
  end
`endif

  // Y select: modes are mutually exclusive, so each source is masked and OR-ed;
  // BLACK contributes nothing and leaves Y at zero
  always_comb begin
    y_s = 8'h00;
    for (int k = 0; k < LANES; k++) begin
      y_s = y_s | ({8{active_mode_q == MODE_W'(k)}} & bus.in_data[8*k +: 8]);
    end
`ifdef YUV_LANE_SELECT_PATTERN_EN
    y_s = y_s | ({8{active_mode_q == MODE_W'(PATTERN)}} &
                 (pix_cnt_q[7:0] ^ {7'b000_0000, parity_q}));
`endif
  end

  // Output word is captured only on valid beats and held otherwise
  always_comb begin
    yuv_data_d  = yuv_data_q;
    yuv_valid_d = 1'b0;
    if (bus.in_valid) begin
      yuv_data_d  = {y_s, U_CONST, V_CONST};
      yuv_valid_d = 1'b1;
    end else begin
      yuv_data_d  = yuv_data_q;
      yuv_valid_d = 1'b0;
    end
  end

  // Active-low one-hot LED drive
  always_comb begin
    mode_led_n_s = {NMODES{1'b1}};
    for (int k = 0; k < NMODES; k++) begin
      mode_led_n_s[k] = (active_mode_q != MODE_W'(k));
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_mode_q <= {MODE_W{1'b0}};
      active_mode_q  <= {MODE_W{1'b0}};
      vs_q           <= 1'b0;
      armed_q        <= 1'b0;
      yuv_data_q     <= {8'h00, U_CONST, V_CONST};
      yuv_valid_q    <= 1'b0;
    end else begin
      pending_mode_q <= pending_mode_d;
      active_mode_q  <= active_mode_d;
      vs_q           <= vs_d;
      armed_q        <= armed_d;
      yuv_data_q     <= yuv_data_d;
      yuv_valid_q    <= yuv_valid_d;
    end
  end

`ifdef YUV_LANE_SELECT_PATTERN_EN
  // Pattern state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt_q <= 16'h0000;
      parity_q  <= 1'b0;
    end else begin
      pix_cnt_q <= pix_cnt_d;
      parity_q  <= parity_d;
    end
  end
`endif

  assign bus.yuv_data    = yuv_data_q;
  assign bus.yuv_valid   = yuv_valid_q;
  assign bus.active_mode = active_mode_q;
  assign bus.mode_led_n  = mode_led_n_s;

endmodule

// File: tb/tb_yuv_lane_select.sv
// Randomized bench for yuv_lane_select against a frame-level behavioural model,
// plus directed scenarios with fixed expected values.
module tb_yuv_lane_select;
  localparam int DATA_WD = 16;
  localparam int LANES   = DATA_WD / 8;
`ifdef YUV_LANE_SELECT_PATTERN_EN
  localparam int NMODES  = LANES + 2;
`else
  localparam int NMODES  = LANES + 1;
`endif
  localparam int BLACK   = NMODES - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  yuv_lane_select_if #(.DATA_WD(DATA_WD)) bus();

  yuv_lane_select #(.DATA_WD(DATA_WD), .U_CONST(8'h80), .V_CONST(8'h80)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int          m_pending, m_active, m_cnt, m_parity;
  bit          m_vs_prev, m_seen_low, m_valid;
  logic [23:0] m_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_led(input int m);
    logic [31:0] r;
    r = 32'h0;
    for (int k = 0; k < NMODES; k++) r[k] = (k != m);
    return r;
  endfunction

  function automatic logic [7:0] model_y(input logic [DATA_WD-1:0] d);
    if (m_active < LANES) return 8'(d >> (8 * m_active));
`ifdef YUV_LANE_SELECT_PATTERN_EN
    if (m_active == LANES) return 8'((m_cnt % 256) ^ m_parity);
`endif
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_pending = 0; m_active = 0; m_cnt = 0; m_parity = 0;
    m_vs_prev = 1'b0; m_seen_low = 1'b0; m_valid = 1'b0;
    m_data = 24'h008080;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, 32'(bus.yuv_valid), 32'(m_valid));
    check({tag, ".data"},  32'(bus.yuv_data),  32'(m_data));
    check({tag, ".mode"},  32'(bus.active_mode), 32'(m_active));
    check({tag, ".led"},   32'(bus.mode_led_n), exp_led(m_active));
  endtask

  // one clock: drive inputs, advance the model over the edge, compare after the edge
  task automatic cycle(input bit ms, input bit v, input bit iv, input logic [DATA_WD-1:0] d);
    bit fs;
    bus.mode_step = ms; bus.vs = v; bus.in_valid = iv; bus.in_data = d;
    @(posedge clk);
    fs = v && !m_vs_prev && m_seen_low;
    if (iv) begin
      m_data  = {model_y(d), 8'h80, 8'h80};
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    if (fs) m_active = m_pending;
    if (ms) m_pending = (m_pending + 1) % NMODES;
    if (fs) begin
      m_cnt = 0;
      m_parity = 1 - m_parity;
    end else if (iv) begin
      m_cnt = (m_cnt + 1) % 65536;
    end
    if (!v) m_seen_low = 1'b1;
    m_vs_prev = v;
    #1;
    check_all("model");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check("rst.mode",  32'(bus.active_mode), 32'd0);
    check("rst.valid", 32'(bus.yuv_valid),   32'd0);
    check("rst.data",  32'(bus.yuv_data),    32'h008080);
    check("rst.led",   32'(bus.mode_led_n),  exp_led(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bus.mode_step = 1'b0; bus.vs = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    do_reset();
    cycle(0, 0, 0, 16'h0000);

    // lane select, then step + frame edge
    cycle(0, 0, 1, 16'hA55A);
    check("lane0.data",  32'(bus.yuv_data),  32'h5A8080);
    check("lane0.valid", 32'(bus.yuv_valid), 32'd1);
    cycle(1, 0, 0, 16'h0000);
    check("lane0.hold", 32'(bus.yuv_data), 32'h5A8080);
    cycle(0, 1, 0, 16'h0000);
    check("lane1.mode", 32'(bus.active_mode), 32'd1);
    cycle(0, 1, 1, 16'hA55A);
    check("lane1.data", 32'(bus.yuv_data), 32'hA58080);
    cycle(0, 0, 0, 16'h0000);

    // deferral: stepping mid-frame changes nothing until the next edge
    cycle(1, 0, 1, 16'h1234);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 1, 16'(i * 16'h1111));
      check("defer.mode", 32'(bus.active_mode), 32'd1);
    end
    cycle(0, 1, 0, 16'h0000);
    check("defer.edge", 32'(bus.active_mode), 32'd2);
    cycle(0, 0, 0, 16'h0000);

    // step/vs collision with pending == 1
    while (m_pending != 1) cycle(1, 0, 0, 16'h0000);
    cycle(1, 1, 0, 16'h0000);
    check("coll.active", 32'(bus.active_mode), 32'd1);
    cycle(0, 0, 0, 16'h0000);
    cycle(0, 1, 0, 16'h0000);
    check("coll.pending", 32'(bus.active_mode), 32'd2);
    cycle(0, 0, 0, 16'h0000);

    // wrap through every mode from reset
    do_reset();
    cycle(0, 0, 0, 16'h0000);
    for (int i = 0; i < NMODES; i++) begin
      cycle(1, 0, 0, 16'h0000);
      cycle(0, 1, 0, 16'h0000);
      check("wrap.mode", 32'(bus.active_mode), 32'((i + 1) % NMODES));
      cycle(0, 1, 1, 16'hA55A);
      if ((i + 1) % NMODES == BLACK) check("wrap.black", 32'(bus.yuv_data), 32'h008080);
      cycle(0, 0, 0, 16'h0000);
    end

    // asynchronous reset mid-frame
    cycle(1, 0, 0, 16'h0000);
    cycle(1, 0, 0, 16'h0000);
    cycle(0, 1, 1, 16'hBEEF);
    cycle(0, 1, 1, 16'hBEEF);
    do_reset();

    // vs already high at release is not a frame boundary
    bus.vs = 1'b1;
    do_reset();
    cycle(1, 1, 0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 1, 16'h0102);
      check("vshigh.mode", 32'(bus.active_mode), 32'd0);
    end
    cycle(0, 0, 0, 16'h0000);
    cycle(0, 1, 0, 16'h0000);
    check("vshigh.edge", 32'(bus.active_mode), 32'd1);
    cycle(0, 0, 0, 16'h0000);

`ifdef YUV_LANE_SELECT_PATTERN_EN
    // counting pattern across two frames
    do_reset();
    for (int i = 0; i < LANES; i++) cycle(1, 0, 0, 16'h0000);
    cycle(0, 1, 0, 16'h0000);
    cycle(0, 0, 0, 16'h0000);
    cycle(0, 1, 0, 16'h0000);
    cycle(0, 0, 0, 16'h0000);
    check("pat.mode", 32'(bus.active_mode), 32'(LANES));
    for (int i = 0; i < 300; i++) begin
      cycle(0, 0, 1, 16'($urandom));
      check("pat.y", 32'(bus.yuv_data[23:16]), 32'(i % 256));
    end
    cycle(0, 1, 0, 16'h0000);
    cycle(0, 1, 1, 16'h0000);
    check("pat.next", 32'(bus.yuv_data[23:16]), 32'h01);
    cycle(0, 0, 0, 16'h0000);
`endif

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit v;
      v = bus.vs;
      if ($urandom_range(0, 15) == 0) v = ~v;
      cycle($urandom_range(0, 7) == 0, v, $urandom_range(0, 1) == 1, DATA_WD'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
